instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequential instruction-fetch stage of the RISC-V core. Owns the program counter and issues word fetches to instruction memory over a req/ack handshake. Buffers each returned word and presents it with a valid/ready handshake to decode, where `opcode` drives the control unit directly. Accepts PC redirects from branch/JAL resolution and squashes in-flight or buffered wrong-path fetches.

## Interface

**Parameters**
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.

**Ports**
- `clk` in, 1: single clock; all state updates on the rising edge.
- `reset` in, 1: asynchronous, active-high reset.
- `imem_req` out, 1: fetch request to instruction memory.
- `imem_addr` out, 32: fetch address; held stable while `imem_req` is 1 and `imem_ack` is 0.
- `imem_ack` in, 1: memory completes the request this cycle; `imem_rdata` is valid this cycle.
- `imem_rdata` in, 32: fetched instruction word.
- `instr_valid` out, 1: `instr`, `pc_out` and `opcode` hold a fetched instruction.
- `instr_ready` in, 1: decode accepts the instruction this cycle.
- `instr` out, 32: buffered instruction.
- `opcode` out, 7: `instr[6:0]`, feeds the control unit.
- `pc_out` out, 32: address of `instr`.
- `redirect` in, 1: taken branch or JAL; next fetch comes from `redirect_pc`.
- `redirect_pc` in, 32: redirect target.
- `fetch_err` out, 1: sticky misaligned-redirect error.
- `instr_count` out, 32: number of accepted instructions.

## Operation

- **States**
  - IDLE: entered on reset. Always goes to REQ on the next edge.
  - REQ: `imem_req`=1. On `imem_ack`, go to HOLD, unless the fetch is squashed.
  - HOLD: `instr_valid`=1. On `instr_ready` or `redirect`, go to REQ.
  - HALT: entered on error; absorbing until reset.
- **Handshakes**
  - An instruction is accepted when `instr_valid` and `instr_ready` are both 1 on an edge.
  - On acceptance, `instr_count` increments by 1, wrapping at 2^32.
- **PC update**
  - Sequential next PC is `pc + 4`, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
  - The PC advances only when a HOLD instruction is accepted.
- **Redirect in HOLD**
  - The buffered instruction is dropped, unless `instr_ready` is also 1. In that case it counts as accepted.
  - Either way, the next fetch address is `redirect_pc`.
- **Redirect in REQ**
  - The current request is not withdrawn; `imem_req` and `imem_addr` stay stable until ack.
  - A `kill` flag is set and `redirect_pc` is latched.
  - On ack with `kill` set, `imem_rdata` is discarded, `kill` is cleared, and a new request is issued to the latched target. The FSM stays in REQ.
  - If redirect and ack occur in the same cycle, the returned data is discarded and the next request goes to `redirect_pc`.
  - On repeated redirects before ack, the latest target wins.
- **Redirect in IDLE**
  - The first fetch goes to `redirect_pc` instead of `RESET_PC`.
- **Misaligned redirect**
  - `redirect` with `redirect_pc[1:0]` != 0 sets `fetch_err` and moves the FSM to HALT.
  - If a request is outstanding, the move to HALT waits for its ack; `imem_req` stays 1 until then.
  - In HALT: `imem_req`=0 and `instr_valid`=0.

## Timing

- **Reset values** (all apply immediately on reset assertion):
  - `imem_req`=0, `imem_addr`=`RESET_PC`
  - `instr_valid`=0, `instr`=32'h0000_0013 (NOP), `opcode`=7'b0010011
  - `pc_out`=`RESET_PC`, `fetch_err`=0, `instr_count`=0
  - `kill`=0, state IDLE
- Reset asserted mid-request drops the request immediately; the late ack is ignored.
- **Latency**
  - `imem_req` rises 1 cycle after reset deasserts.
  - `instr_valid` rises on the edge after `imem_ack`.
  - Zero-wait memory with `instr_ready` tied to 1 sustains 1 instruction per 2 cycles.
- `instr`, `pc_out` and `opcode` are registered. They change only on the REQ-to-HOLD transition or on reset.
- `opcode` always equals `instr[6:0]`.

## Structure

- **Package `fetch_pkg`**
  - State enum: IDLE/REQ/HOLD/HALT.
  - `NOP_INSTR` = 32'h0000_0013.
  - RV32I opcode constants (R, LOAD, OP-IMM, STORE, BRANCH, JAL), shared with the control unit.
  - `PC_STEP` = 4.
- **Sub-module `pc_register`**
  - 32-bit PC with async reset to `RESET_PC`.
  - Inputs `load`/`load_val`/`incr`; `load` has priority over `incr`.

## Test plan

- **Reset and first fetch.** Reset, `RESET_PC`=0x100, zero-wait ack, `instr_ready`=1.
  - `imem_addr` sequence: 0x100, 0x104, 0x108.
  - `instr_count`=3 after 6 cycles of valid handshakes.
- **Backpressure.** Hold `instr_ready`=0 for 5 cycles.
  - `instr_valid` stays 1; `instr` and `pc_out` are stable; no new `imem_req`; `instr_count` unchanged.
- **Redirect in flight.** Request to 0x200 outstanding with 3-cycle ack latency; pulse `redirect` to 0x400 in cycle 1.
  - 0x200 data is discarded, the next request goes to 0x400, and `pc_out`=0x400 is presented.
- **Simultaneous redirect and ack.** Redirect to 0x80 in the same cycle as ack of 0x10.
  - `instr_valid` stays 0 and the next `imem_addr`=0x80.
- **Redirect in HOLD with ready.** Redirect in HOLD with `instr_ready`=1.
  - `instr_count` increments and the next fetch goes to the redirect target.
- **Wrap and error.**
  - PC at 0xFFFF_FFFC: after acceptance, the next `imem_addr`=0x0.
  - Redirect to 0x202: `fetch_err`=1, HALT, no further `imem_req` until reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the reset NOP, RV32I major opcodes (also consumed by the control unit)
// and the sequential PC increment.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2,
      ST_HALT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
   localparam logic [31:0] PC_STEP   = 32'd4;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter register.
//   clk_i/rst_i  : clock, async active-high reset (loads RESET_PC)
//   load_i       : load load_val_i (wins over incr_i)
//   incr_i       : advance by PC_STEP, wrapping modulo 2^32
//   pc_o         : current PC
module pc_register
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] load_val_i,
   input  logic        incr_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       pc_q <= RESET_PC;
      else if (load_i) pc_q <= load_val_i;
      else if (incr_i) pc_q <= pc_q + PC_STEP;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch: one outstanding imem request at a time,
// the returned word is buffered and offered to decode via valid/ready.
//   clk_i, reset_i                   : clock, async active-high reset
//   imem_req_o/imem_addr_o           : fetch request, address held until ack
//   imem_ack_i/imem_rdata_i          : completion and returned word
//   instr_valid_o/instr_ready_i      : decode handshake
//   instr_o/opcode_o/pc_out_o        : buffered instruction and its address
//   redirect_i/redirect_pc_i         : taken branch / JAL target
//   fetch_err_o                      : sticky misaligned-redirect flag
//   instr_count_o                    : accepted-instruction counter
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [6:0]  opcode_o,
   output logic [31:0] pc_out_o,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        fetch_err_o,
   output logic [31:0] instr_count_o
);

   fetch_state_e state_q, state_d;
   logic         kill_q, kill_d;
   logic [31:0]  kill_pc_q, kill_pc_d;
   logic         err_pend_q, err_pend_d;   // misaligned redirect waiting for ack
   logic         err_q, err_d;
   logic [31:0]  instr_q, pc_out_q, count_q;
   logic [31:0]  pc;
   logic         pc_load, pc_incr, capture, accept;
   logic [31:0]  pc_load_val;
   logic         mis;

   assign mis = redirect_i && is_misaligned(redirect_pc_i);

   pc_register #(.RESET_PC(RESET_PC)) u_pc (
      .clk_i      (clk_i),
      .rst_i      (reset_i),
      .load_i     (pc_load),
      .load_val_i (pc_load_val),
      .incr_i     (pc_incr),
      .pc_o       (pc)
   );

   always_comb begin
      state_d     = state_q;
      kill_d      = kill_q;
      kill_pc_d   = kill_pc_q;
      err_pend_d  = err_pend_q;
      err_d       = err_q;
      pc_load     = 1'b0;
      pc_load_val = redirect_pc_i;
      pc_incr     = 1'b0;
      capture     = 1'b0;
      accept      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
            if (mis) begin
               err_d   = 1'b1;
               state_d = ST_HALT;
            end else if (redirect_i) begin
               pc_load = 1'b1;
            end
         end
         ST_REQ: begin
            // The request is never withdrawn: the PC (imem address) only
            // moves on ack, a redirect meanwhile is parked in kill_pc.
            if (mis) begin
               err_d      = 1'b1;
               err_pend_d = 1'b1;
            end
            if (imem_ack_i) begin
               kill_d = 1'b0;
               if (err_pend_d) begin
                  state_d = ST_HALT;
               end else if (redirect_i) begin
                  pc_load = 1'b1;
               end else if (kill_q) begin
                  pc_load     = 1'b1;
                  pc_load_val = kill_pc_q;
               end else begin
                  capture = 1'b1;
                  state_d = ST_HOLD;
               end
            end else if (redirect_i && !mis) begin
               kill_d    = 1'b1;
               kill_pc_d = redirect_pc_i;
            end
         end
         ST_HOLD: begin
            accept = instr_ready_i;
            if (mis) begin
               err_d   = 1'b1;
               state_d = ST_HALT;
            end else if (redirect_i) begin
               pc_load = 1'b1;
               state_d = ST_REQ;
            end else if (instr_ready_i) begin
               pc_incr = 1'b1;
               state_d = ST_REQ;
            end
         end
         default: ;  // ST_HALT absorbs until reset
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         kill_q     <= 1'b0;
         kill_pc_q  <= RESET_PC;
         err_pend_q <= 1'b0;
         err_q      <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_out_q   <= RESET_PC;
         count_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         kill_q     <= kill_d;
         kill_pc_q  <= kill_pc_d;
         err_pend_q <= err_pend_d;
         err_q      <= err_d;
         if (capture) begin
            instr_q  <= imem_rdata_i;
            pc_out_q <= pc;
         end
         if (accept) count_q <= count_q + 32'd1;
      end
   end

   assign imem_req_o    = (state_q == ST_REQ);
   assign imem_addr_o   = pc;
   assign instr_valid_o = (state_q == ST_HOLD);
   assign instr_o       = instr_q;
   assign opcode_o      = instr_q[6:0];
   assign pc_out_o      = pc_out_q;
   assign fetch_err_o   = err_q;
   assign instr_count_o = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with RESET_PC = 0x100.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_ack, instr_valid, instr_ready, redirect, fetch_err;
   logic [31:0] imem_addr, imem_rdata, instr, pc_out, redirect_pc, instr_count;
   logic [6:0]  opcode;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
      .clk_i         (clk),
      .reset_i       (rst),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ack_i    (imem_ack),
      .imem_rdata_i  (imem_rdata),
      .instr_valid_o (instr_valid),
      .instr_ready_i (instr_ready),
      .instr_o       (instr),
      .opcode_o      (opcode),
      .pc_out_o      (pc_out),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .fetch_err_o   (fetch_err),
      .instr_count_o (instr_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Complete the current request with zero wait: DUT is in HOLD afterwards.
   task automatic fetch(input logic [31:0] w);
      imem_ack   = 1'b1;
      imem_rdata = w;
      step();
      imem_ack   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      redirect = 1'b0; redirect_pc = '0;
      step(); step();
      chk("rst_req",   {31'd0, imem_req},    32'd0);
      chk("rst_addr",  imem_addr,            32'h100);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr,                32'h13);
      chk("rst_opc",   {25'd0, opcode},      32'h13);
      chk("rst_pcout", pc_out,               32'h100);
      chk("rst_err",   {31'd0, fetch_err},   32'd0);
      chk("rst_cnt",   instr_count,          32'd0);

      // reset release and streaming fetch
      rst = 1'b0;
      step();
      chk("first_req",  {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr,         32'h100);
      instr_ready = 1'b1;
      fetch(32'h0050_0093);
      chk("h0_valid", {31'd0, instr_valid}, 32'd1);
      chk("h0_instr", instr,                32'h0050_0093);
      chk("h0_opc",   {25'd0, opcode},      32'h13);
      chk("h0_pc",    pc_out,               32'h100);
      chk("h0_req",   {31'd0, imem_req},    32'd0);
      step();
      chk("s1_cnt",  instr_count, 32'd1);
      chk("s1_addr", imem_addr,   32'h104);
      fetch(32'h00A0_0113);
      chk("h1_pc", pc_out, 32'h104);
      step();
      chk("s2_cnt",  instr_count, 32'd2);
      chk("s2_addr", imem_addr,   32'h108);
      fetch(32'h0020_81B3);
      chk("h2_opc", {25'd0, opcode}, 32'h33);
      chk("h2_pc",  pc_out,          32'h108);
      step();
      chk("s3_cnt",  instr_count, 32'd3);
      chk("s3_addr", imem_addr,   32'h10C);

      // backpressure
      instr_ready = 1'b0;
      fetch(32'h0000_A283);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid", {31'd0, instr_valid}, 32'd1);
         chk("bp_instr", instr,                32'h0000_A283);
         chk("bp_pc",    pc_out,               32'h10C);
         chk("bp_req",   {31'd0, imem_req},    32'd0);
         chk("bp_cnt",   instr_count,          32'd3);
      end
      instr_ready = 1'b1;
      step();
      chk("bp_rel_cnt",  instr_count, 32'd4);
      chk("bp_rel_addr", imem_addr,   32'h110);
      instr_ready = 1'b0;

      // redirect in HOLD without ready: buffered word dropped
      fetch(32'h0000_0063);
      redirect = 1'b1; redirect_pc = 32'h10;
      step();
      redirect = 1'b0;
      chk("hd_cnt",   instr_count,          32'd4);
      chk("hd_valid", {31'd0, instr_valid}, 32'd0);
      chk("hd_addr",  imem_addr,            32'h10);
      chk("hd_pcout", pc_out,               32'h110);

      // redirect together with ack
      imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      redirect = 1'b1; redirect_pc = 32'h80;
      step();
      imem_ack = 1'b0; redirect = 1'b0;
      chk("ra_valid", {31'd0, instr_valid}, 32'd0);
      chk("ra_req",   {31'd0, imem_req},    32'd1);
      chk("ra_addr",  imem_addr,            32'h80);
      chk("ra_instr", instr,                32'h0000_0063);
      fetch(32'h0000_006F);
      chk("ra_pcout", pc_out, 32'h80);
      redirect = 1'b1; redirect_pc = 32'h200;
      step();
      chk("to200_addr", imem_addr, 32'h200);

      // redirects in flight, latest target wins
      redirect_pc = 32'h300;
      step();
      redirect_pc = 32'h400;
      chk("if_hold1", imem_addr, 32'h200);
      step();
      redirect = 1'b0;
      chk("if_hold2", imem_addr,          32'h200);
      chk("if_req",   {31'd0, imem_req}, 32'd1);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      chk("if_valid", {31'd0, instr_valid}, 32'd0);
      chk("if_addr",  imem_addr,            32'h400);
      fetch(32'h0000_0023);
      chk("if_pcout", pc_out,          32'h400);
      chk("if_instr", instr,           32'h0000_0023);
      chk("if_opc",   {25'd0, opcode}, 32'h23);

      // redirect in HOLD with ready: accepted and redirected
      instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      chk("hr_cnt",   instr_count,          32'd5);
      chk("hr_addr",  imem_addr,            32'hFFFF_FFFC);
      chk("hr_valid", {31'd0, instr_valid}, 32'd0);

      // PC wrap
      fetch(32'h0000_0013);
      chk("wr_pcout", pc_out, 32'hFFFF_FFFC);
      step();
      chk("wr_cnt",  instr_count, 32'd6);
      chk("wr_addr", imem_addr,   32'h0);

      // misaligned redirect while a request is outstanding
      instr_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h202;
      step();
      redirect = 1'b0;
      chk("er_flag", {31'd0, fetch_err}, 32'd1);
      chk("er_req",  {31'd0, imem_req},  32'd1);
      chk("er_addr", imem_addr,          32'h0);
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      step();
      imem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("halt_req",   {31'd0, imem_req},    32'd0);
         chk("halt_valid", {31'd0, instr_valid}, 32'd0);
         chk("halt_err",   {31'd0, fetch_err},   32'd1);
         step();
      end
      chk("halt_cnt", instr_count, 32'd6);

      // reset clears, redirect in IDLE picks the first fetch address
      rst = 1'b1;
      #1;
      chk("rst2_err", {31'd0, fetch_err}, 32'd0);
      chk("rst2_cnt", instr_count,        32'd0);
      chk("rst2_pc",  imem_addr,          32'h100);
      step();
      rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
      step();
      redirect = 1'b0;
      chk("idle_req",  {31'd0, imem_req}, 32'd1);
      chk("idle_addr", imem_addr,         32'h40);

      // reset mid-request drops the request at once; late ack ignored
      rst = 1'b1;
      #1;
      chk("rmid_req",  {31'd0, imem_req}, 32'd0);
      chk("rmid_addr", imem_addr,         32'h100);
      imem_ack = 1'b1;
      step();
      rst = 1'b0; imem_ack = 1'b0;
      step();
      chk("rmid_req2",   {31'd0, imem_req},    32'd1);
      chk("rmid_addr2",  imem_addr,            32'h100);
      chk("rmid_valid",  {31'd0, instr_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
